div_iter_unit: RTL
==================

Name: div_iter_unit

Overview:
- Iterative radix-2 restoring divider. It is the responder end of the execute stage's divide request/ready protocol (divsel, a, b in; ready, res out).
- Implements RV32M DIV/DIVU/REM/REMU with spec-exact divide-by-zero and overflow results.
- Holds its result until the pipeline consumes it, so execute stalls (dbg, mem_hold, f_stall) never lose a result.
- Sits beside the ALU in the EX stage. Operands are the forwarded ALU operands.

Parameters:
- XLEN, 32, operand/result width.
- CNT_W, 5, iteration counter width (log2 XLEN).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- divsel  in  3  bit2 = request valid, bit1 = remainder (1) / quotient (0), bit0 = unsigned (1) / signed (0); 3'b0xx = no request.
- a  in  XLEN  dividend (forwarded rs1).
- b  in  XLEN  divisor (forwarded rs2).
- hold  in  1  pipeline stalled this cycle; result must not be retired.
- flush  in  1  squash the in-flight divide (branch/trap kill).
- busy  out  1  divide in progress; hazard unit stalls ID/EX while high.
- ready  out  1  res valid for the current request.
- res  out  XLEN  quotient or remainder.

Behaviour:
- Reset (rst_n low, async): state=IDLE, busy=0, ready=0, res=0, count=0, all datapath registers 0. Reset mid-divide aborts immediately with no residue.
- States: IDLE, BUSY, DONE.
- IDLE, divsel[2]=1, flush=0:
  - Capture op = divsel[1:0].
  - Capture |a| and |b|: magnitude when signed, raw when unsigned.
  - Capture sign_q = a[31]^b[31] and sign_r = a[31] (both 0 if unsigned).
  - Next state:
    - b==0 -> DONE; res = (rem ? a : all-ones).
    - Signed, a==32'h8000_0000, b==all-ones -> DONE; res = (rem ? 0 : 32'h8000_0000).
    - Otherwise -> BUSY; count=XLEN-1, rem_reg=0, quo_reg=|a|.
- BUSY, each cycle:
  - Shift {rem_reg, quo_reg} left by 1.
  - Trial = rem_shifted - |b| (XLEN+1 bits). If non-negative, rem_reg = trial and quo LSB = 1; else quo LSB = 0.
  - count decrements. On the iteration with count==0, go to DONE.
  - res = selected quotient/remainder, two's-complement negated when sign_q (quotient) or sign_r (remainder) is set. Result is registered.
- Latency:
  - Normal divide: request sampled in cycle 0, BUSY cycles 1..32, ready=1 from cycle 33.
  - Special cases: ready=1 from cycle 1.
- DONE:
  - ready=1, busy=0, res stable.
  - hold=1 -> stay in DONE.
  - hold=0 -> result retired; next state IDLE, ready=0.
  - The request still on divsel in the retire cycle must not restart. IDLE only samples from the cycle after retirement, when ID/EX has advanced.
- busy=1 exactly in the cycle a request is accepted and in all BUSY cycles. This lets the hazard unit freeze ID/EX, so a, b and divsel are only sampled at acceptance.
- flush=1 in any state -> next state IDLE, ready=0, busy=0. res keeps its value. flush has priority over acceptance and over completion.
- divsel changes during BUSY are ignored; the operands are already captured.
- Operand-change-within-DONE is not detected. The pipeline guarantees a retire or flush first.
- ready is never combinationally dependent on divsel/a/b. res only changes on entry to DONE or on reset.

Decomposition:
- Shared package (riscv_pkg) holds:
  - divsel field constants: DIVSEL_VALID=2, DIVSEL_REM=1, DIVSEL_UNS=0.
  - Opcode constants DIV=3'b100, DIVU=3'b101, REM=3'b110, REMU=3'b111.
  - State enum div_state_t {IDLE, BUSY, DONE}.
- One natural sub-module: div_iter_step. It is combinational: one restoring shift/subtract step taking rem, quo and divisor, returning next rem/quo. It is reused if a radix-4 (two steps/cycle) variant is built later.

Test Plan:
- DIVU a=100, b=7, hold=0 -> busy cycles 0-32, ready=1 at cycle 33, res=14; retire; ready=0 at cycle 34. REMU same operands -> res=2.
- DIV a=-100 (32'hFFFF_FF9C), b=7 -> res=-14 (32'hFFFF_FFF2). REM same operands -> res=-2 (32'hFFFF_FFFE), sign of dividend.
- Divide by zero:
  - DIV a=5, b=0 -> ready at cycle 1, res=32'hFFFF_FFFF.
  - REMU a=5, b=0 -> res=5.
  - Overflow DIV a=32'h8000_0000, b=32'hFFFF_FFFF -> res=32'h8000_0000; REM -> res=0.
- DIVU a=1000, b=10, hold held high for 5 cycles after ready -> ready and res=100 stable all 5 cycles, no restart; after hold drops, one cycle to IDLE, then a new DIVU 9/3 -> res=3.
- Flush and reset abort:
  - flush pulsed at cycle 10 of a DIVU -> busy=0, ready=0 next cycle, state IDLE; a subsequent DIVU 50/5 -> res=10 with correct 33-cycle latency.
  - rst_n asserted mid-BUSY -> all outputs 0 immediately (async).

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared definitions for the EX-stage divide unit: divsel field positions,
// divide opcodes as presented on divsel, and the divider state encoding.
package riscv_pkg;

  // Bit positions inside divsel.
  localparam int DIVSEL_VALID = 2;
  localparam int DIVSEL_REM   = 1;
  localparam int DIVSEL_UNS   = 0;

  // Full divsel encodings for the four RV32M divide instructions.
  localparam logic [2:0] DIV  = 3'b100;
  localparam logic [2:0] DIVU = 3'b101;
  localparam logic [2:0] REM  = 3'b110;
  localparam logic [2:0] REMU = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/div_iter_step.sv
// One radix-2 restoring divide step: shift {rem, quo} left by one, try to
// subtract the divisor from the partial remainder, and keep the difference
// (quotient bit 1) only when it does not go negative.
module div_iter_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] quo_o
);

  logic [XLEN:0]   rem_shift;
  logic            fits;
  logic [XLEN-1:0] diff;

  // Trial subtraction; the shifted remainder needs XLEN+1 bits, but whenever
  // the subtraction succeeds the difference is below the divisor and fits in
  // XLEN bits, so the low XLEN bits of the modular difference are exact.
  always_comb begin
    rem_shift = {rem_i, quo_i[XLEN-1]};
    fits      = (rem_shift >= {1'b0, divisor_i});
    diff      = rem_shift[XLEN-1:0] - divisor_i;
    rem_o     = fits ? diff : rem_shift[XLEN-1:0];
    quo_o     = {quo_i[XLEN-2:0], fits};
  end

endmodule

// File: rtl/div_iter_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Accepts a request from IDLE, iterates XLEN cycles in BUSY, then holds the
// registered result in DONE until the pipeline retires it (hold low) or
// flushes it. Divide-by-zero and signed overflow finish in one cycle.
module div_iter_unit
  import riscv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [2:0]      divsel,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            hold,
  input  logic            flush,
  output logic            busy,
  output logic            ready,
  output logic [XLEN-1:0] res
);

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  div_state_t       state_q, state_d;
  logic             rem_sel_q, rem_sel_d;
  logic             sign_quo_q, sign_quo_d;
  logic             sign_rem_q, sign_rem_d;
  logic [XLEN-1:0]  divisor_q, divisor_d;
  logic [XLEN-1:0]  rem_q, rem_d;
  logic [XLEN-1:0]  quo_q, quo_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [XLEN-1:0]  res_q, res_d;

  logic [XLEN-1:0]  step_rem, step_quo;
  logic             is_signed, a_neg, b_neg, accept;
  logic [XLEN-1:0]  abs_a, abs_b;

  div_iter_step #(.XLEN(XLEN)) u_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (divisor_q),
    .rem_o     (step_rem),
    .quo_o     (step_quo)
  );

  // Operand decode for a request presented in IDLE.
  always_comb begin
    is_signed = ~divsel[DIVSEL_UNS];
    a_neg     = is_signed & a[XLEN-1];
    b_neg     = is_signed & b[XLEN-1];
    abs_a     = a_neg ? -a : a;
    abs_b     = b_neg ? -b : b;
    accept    = (state_q == IDLE) & divsel[DIVSEL_VALID] & ~flush;
  end

  // Next-state and datapath update logic.
  always_comb begin
    // NOTE: every signal gets a default before the case so that no path
    // leaves it unassigned; a missing default would infer a latch.
    state_d    = state_q;
    rem_sel_d  = rem_sel_q;
    sign_quo_d = sign_quo_q;
    sign_rem_d = sign_rem_q;
    divisor_d  = divisor_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    count_d    = count_q;
    res_d      = res_q;
    busy       = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          busy       = rst_n;
          rem_sel_d  = divsel[DIVSEL_REM];
          sign_quo_d = a_neg ^ b_neg;
          sign_rem_d = a_neg;
          divisor_d  = abs_b;
          if (b == '0) begin
            state_d = DONE;
            res_d   = divsel[DIVSEL_REM] ? a : '1;
          end else if (is_signed && (a == INT_MIN) && (b == '1)) begin
            state_d = DONE;
            res_d   = divsel[DIVSEL_REM] ? '0 : INT_MIN;
          end else begin
            state_d = BUSY;
            count_d = CNT_W'(XLEN - 1);
            rem_d   = '0;
            quo_d   = abs_a;
          end
        end
      end

      BUSY: begin
        busy    = 1'b1;
        rem_d   = step_rem;
        quo_d   = step_quo;
        count_d = count_q - 1'b1;
        if (count_q == '0) begin
          state_d = DONE;
          if (rem_sel_q) res_d = sign_rem_q ? -step_rem : step_rem;
          else           res_d = sign_quo_q ? -step_quo : step_quo;
        end
      end

      DONE: begin
        if (!hold) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    // A squash beats both acceptance and completion; the old result stays.
    if (flush) begin
      state_d = IDLE;
      res_d   = res_q;
    end
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rem_sel_q  <= 1'b0;
      sign_quo_q <= 1'b0;
      sign_rem_q <= 1'b0;
      divisor_q  <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      count_q    <= '0;
      res_q      <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q    <= state_d;
      rem_sel_q  <= rem_sel_d;
      sign_quo_q <= sign_quo_d;
      sign_rem_q <= sign_rem_d;
      divisor_q  <= divisor_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      count_q    <= count_d;
      res_q      <= res_d;
    end
  end

  assign ready = (state_q == DONE);
  assign res   = res_q;

endmodule
